// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_pkg
// Brief    : Shared state type, constants and helpers for imem_sync_loadable.
// Revision : 1.0
// ============================================================================
package imem_pkg;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_t;

  localparam logic [31:0] NOP_DEFAULT  = 32'h0000_0000;
  localparam int          PARITY_MAX_W = 64;

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] data);
    return ^data;
  endfunction

  function automatic int pc_width(input int addr_w);
    return addr_w + 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : imem_load_ctrl
// Brief    : RUN/LOAD sequencer, write counter and loader handshake.
// Revision : 1.0
// ============================================================================
module imem_load_ctrl
  import imem_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              load_start,
  input  logic              load_valid,
  output logic              load_ready,
  output logic              load_done,
  output logic              busy,
  output logic              run_fetch,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nxt;
  logic              done_nxt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= RUN;
      cnt       <= '0;
      load_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      load_done <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    done_nxt   = 1'b0;
    wr_en      = 1'b0;
    load_ready = 1'b0;
    busy       = 1'b0;
    run_fetch  = 1'b0;
    case (state)
      RUN: begin
        // A load request steals the cycle from fetch.
        if (load_start) begin
          state_nxt = LOAD;
          cnt_nxt   = '0;
        end else begin
          run_fetch = 1'b1;
        end
      end
      LOAD: begin
        load_ready = 1'b1;
        busy       = 1'b1;
        if (load_valid) begin
          wr_en = 1'b1;
          if (cnt == LAST_IDX) begin
            state_nxt = RUN;
            done_nxt  = 1'b1;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + ADDR_W'(1);
          end
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  assign wr_addr = cnt;

endmodule
`default_nettype wire

// File: rtl/imem_sync_loadable.sv
`default_nettype none
// ============================================================================
// Module   : imem_sync_loadable
// Brief    : Registered-read instruction memory with stall/flush, address
//            error flag and sequential loader. IMEM_PARITY_EN adds parity_err.
// Revision : 1.0
// ============================================================================
module imem_sync_loadable
  import imem_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 32,
  parameter int                ADDR_W   = 5,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_DEFAULT)
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic [pc_width(ADDR_W)-1:0]  pc,
  input  logic                         fetch_en,
  input  logic                         flush,
  output logic [DATA_W-1:0]            instr,
  output logic                         instr_valid,
  output logic                         addr_err,
`ifdef IMEM_PARITY_EN
  output logic                         parity_err,
`endif
  input  logic                         load_start,
  input  logic                         load_valid,
  input  logic [DATA_W-1:0]            load_data,
  output logic                         load_ready,
  output logic                         load_done,
  output logic                         busy
);

  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  logic              run_fetch;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_idx;
  logic              misaligned;
  logic              in_range;
  logic [DATA_W-1:0] mem [DEPTH];

  imem_load_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_load_ctrl (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_done  (load_done),
    .busy       (busy),
    .run_fetch  (run_fetch),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr)
  );

  assign rd_idx     = pc[ADDR_W+1:2];
  assign misaligned = |pc[1:0];
  // No aliasing: indices past the populated depth are errors.
  assign in_range   = ({1'b0, rd_idx} < DEPTH_LIM);

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_addr] <= load_data;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      instr       <= NOP_WORD;
      instr_valid <= 1'b0;
      addr_err    <= 1'b0;
    end else if (!run_fetch || flush) begin
      instr       <= NOP_WORD;
      instr_valid <= 1'b0;
      addr_err    <= 1'b0;
    end else if (fetch_en) begin
      if (misaligned || !in_range) begin
        instr       <= NOP_WORD;
        instr_valid <= 1'b0;
        addr_err    <= 1'b1;
      end else begin
        instr       <= mem[rd_idx];
        instr_valid <= 1'b1;
        addr_err    <= 1'b0;
      end
    end
  end

`ifdef IMEM_PARITY_EN
  logic                    par_mem [DEPTH];
  logic [PARITY_MAX_W-1:0] wr_ext;
  logic [PARITY_MAX_W-1:0] rd_ext;
  logic                    par_bad;

  always_comb begin
    wr_ext               = '0;
    wr_ext[DATA_W-1:0]   = load_data;
    rd_ext               = '0;
    rd_ext[DATA_W-1:0]   = mem[rd_idx];
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      par_mem[wr_addr] <= even_parity(wr_ext);
    end
  end

  assign par_bad = (par_mem[rd_idx] != even_parity(rd_ext));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      parity_err <= 1'b0;
    end else if (!run_fetch || flush) begin
      parity_err <= 1'b0;
    end else if (fetch_en) begin
      parity_err <= !misaligned && in_range && par_bad;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_sync_loadable.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_sync_loadable
// Brief    : Vector-table and scoreboard bench for imem_sync_loadable.
// Revision : 1.0
// ============================================================================
module tb_imem_sync_loadable;
  import imem_pkg::*;

  localparam int          DEPTH = 32;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic [6:0]  pc = '0;
  logic [6:0]  pc2 = '0;
  logic        fetch_en = 1'b0;
  logic        flush = 1'b0;
  logic        load_start = 1'b0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = '0;
  logic [31:0] instr;
  logic        instr_valid, addr_err, load_ready, load_done, busy;
  logic [31:0] instr2;
  logic        valid2, err2, ready2, done2, busy2;
`ifdef IMEM_PARITY_EN
  logic        parity_err, parity_err2;
`endif

  int checks = 0;
  int failures = 0;
  int dones;
  logic [31:0] model_mem [DEPTH];

  typedef struct {
    logic [6:0]  pc;
    logic [6:0]  pc2;
    logic        fe;
    logic        fl;
    logic [31:0] e_instr;
    logic        e_valid;
    logic        e_err;
    logic        e2_valid;
    logic        e2_err;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        valid;
    logic        err;
    logic        chk2;
    logic        v2;
    logic        e2;
  } exp_t;

  exp_t sb[$];
  vec_t vecs [13];

  imem_sync_loadable #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(5)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .pc          (pc),
    .fetch_en    (fetch_en),
    .flush       (flush),
    .instr       (instr),
    .instr_valid (instr_valid),
    .addr_err    (addr_err),
`ifdef IMEM_PARITY_EN
    .parity_err  (parity_err),
`endif
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .load_done   (load_done),
    .busy        (busy)
  );

  // Shallow instance for the out-of-range boundary; never loaded.
  imem_sync_loadable #(.DATA_W(32), .DEPTH(20), .ADDR_W(5)) dut20 (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .pc          (pc2),
    .fetch_en    (fetch_en),
    .flush       (flush),
    .instr       (instr2),
    .instr_valid (valid2),
    .addr_err    (err2),
`ifdef IMEM_PARITY_EN
    .parity_err  (parity_err2),
`endif
    .load_start  (1'b0),
    .load_valid  (1'b0),
    .load_data   (32'h0),
    .load_ready  (ready2),
    .load_done   (done2),
    .busy        (busy2)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fetch_push(input string name, input logic [6:0] a, input logic [6:0] a2,
                            input logic fe, input logic fl, input logic [31:0] e_instr,
                            input logic e_valid, input logic e_err, input logic chk2,
                            input logic e2v, input logic e2e);
    exp_t e;
    pc = a; pc2 = a2; fetch_en = fe; flush = fl;
    e.name = name; e.instr = e_instr; e.valid = e_valid; e.err = e_err;
    e.chk2 = chk2; e.v2 = e2v; e.e2 = e2e;
    sb.push_back(e);
  endtask

  task automatic tick_pop();
    exp_t e;
    tick();
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_empty: actual=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk({e.name, "_instr"}, instr, e.instr);
      chk({e.name, "_valid"}, instr_valid, e.valid);
      chk({e.name, "_err"}, addr_err, e.err);
      if (e.chk2) begin
        chk({e.name, "_d20_valid"}, valid2, e.v2);
        chk({e.name, "_d20_err"}, err2, e.e2);
      end
    end
  endtask

  task automatic readback(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      fetch_push($sformatf("rd%0d", i), 7'(i * 4), 7'h00, 1'b1, 1'b0,
                 model_mem[i], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick_pop();
    end
    fetch_en = 1'b0;
  endtask

  task automatic run_load(input logic [31:0] base, input logic [31:0] stride,
                          input bit gaps, input int abort_at);
    int written, cyc, ndone, busy_low;
    bit vld;
    pc = 7'h08; fetch_en = 1'b1; flush = 1'b0; load_start = 1'b1;
    tick();
    load_start = 1'b0; fetch_en = 1'b0;
    chk("start_instr", instr, NOP);
    chk("start_valid", instr_valid, 0);
    chk("start_err", addr_err, 0);
    chk("start_busy", busy, 1);
    written = 0; cyc = 0; ndone = 0; busy_low = 0;
    while (written < DEPTH && cyc < 400) begin
      if (written == abort_at) break;
      vld = gaps ? ((cyc % 2) == 0) : 1'b1;
      load_valid = vld;
      load_data  = base + stride * written;
      load_start = gaps && (cyc == 8);
      if (!busy || !load_ready) busy_low++;
      tick();
      cyc++;
      if (vld) begin
        model_mem[written] = base + stride * written;
        written++;
      end
      if (load_done) ndone++;
    end
    load_valid = 1'b0; load_start = 1'b0;
    if (written == abort_at) return;
    chk("load_words", written, DEPTH);
    chk("load_busy_held", busy_low, 0);
    chk("done_pulse", load_done, 1);
    chk("done_busy", busy, 0);
    chk("done_count", ndone, 1);
    tick();
    chk("done_single", load_done, 0);
  endtask

  initial begin
    //            pc     pc2    fe fl instr          v  e  v2 e2
    vecs[0]  = '{7'h08, 7'h4C, 1, 0, 32'h24100002, 1, 0, 1, 0};
    vecs[1]  = '{7'h04, 7'h50, 1, 0, 32'h24100001, 1, 0, 0, 1};
    vecs[2]  = '{7'h10, 7'h00, 0, 0, 32'h24100001, 1, 0, 0, 1};
    vecs[3]  = '{7'h10, 7'h00, 0, 0, 32'h24100001, 1, 0, 0, 1};
    vecs[4]  = '{7'h10, 7'h00, 0, 0, 32'h24100001, 1, 0, 0, 1};
    vecs[5]  = '{7'h10, 7'h00, 0, 1, 32'h00000000, 0, 0, 0, 0};
    vecs[6]  = '{7'h06, 7'h4C, 1, 0, 32'h00000000, 0, 1, 1, 0};
    vecs[7]  = '{7'h06, 7'h50, 0, 0, 32'h00000000, 0, 1, 1, 0};
    vecs[8]  = '{7'h7C, 7'h7C, 1, 0, 32'h2410001F, 1, 0, 0, 1};
    vecs[9]  = '{7'h00, 7'h00, 1, 1, 32'h00000000, 0, 0, 0, 0};
    vecs[10] = '{7'h00, 7'h00, 1, 0, 32'h24100000, 1, 0, 1, 0};
    vecs[11] = '{7'h7D, 7'h4E, 1, 0, 32'h00000000, 0, 1, 0, 1};
    vecs[12] = '{7'h40, 7'h54, 1, 0, 32'h24100010, 1, 0, 0, 1};

    tick();
    tick();
    #2 RST_N = 1'b0;
    #1;
    chk("rst_instr", instr, NOP);
    chk("rst_valid", instr_valid, 0);
    chk("rst_err", addr_err, 0);
    chk("rst_ready", load_ready, 0);
    chk("rst_done", load_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_d20_valid", valid2, 0);
`ifdef IMEM_PARITY_EN
    chk("rst_parity", parity_err, 0);
`endif
    #3 RST_N = 1'b1;
    tick();

    run_load(32'h24100000, 32'h1, 1'b0, -1);

    for (int i = 0; i < 13; i++) begin
      fetch_push($sformatf("vec%0d", i), vecs[i].pc, vecs[i].pc2, vecs[i].fe, vecs[i].fl,
                 vecs[i].e_instr, vecs[i].e_valid, vecs[i].e_err, 1'b1,
                 vecs[i].e2_valid, vecs[i].e2_err);
      tick_pop();
    end

    // Backpressured reload with a stray load_start partway through.
    run_load(32'h8C000000, 32'h00010003, 1'b1, -1);
    readback(0, DEPTH - 1);

    // Abort a reload after ten words.
    run_load(32'h3C000000, 32'h1, 1'b0, 10);
    #2 RST_N = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_ready", load_ready, 0);
    chk("abort_valid", instr_valid, 0);
    #3 RST_N = 1'b1;
    dones = 0;
    repeat (3) begin
      tick();
      if (load_done) dones++;
    end
    chk("abort_no_done", dones, 0);
    chk("abort_run", busy, 0);
    readback(0, 10);

`ifdef IMEM_PARITY_EN
    dut.par_mem[3] = ~dut.par_mem[3];
    fetch_push("par_w3", 7'h0C, 7'h00, 1'b1, 1'b0, model_mem[3], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick_pop();
    chk("par_err_set", parity_err, 1);
    fetch_push("par_w0", 7'h00, 7'h00, 1'b1, 1'b0, model_mem[0], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick_pop();
    chk("par_err_clr", parity_err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_sync_loadable.md
Name: imem_sync_loadable

Overview:
- Parametrised synchronous instruction memory for the pipelined MIPS fetch stage.
- Successor to the fixed 32-word combinational ROM.
- Adds a registered read with 1-cycle latency, plus stall and flush control for the IF/ID boundary.
- Adds address-error detection and a handshaked sequential program loader, so the core can be reprogrammed without re-elaboration.

Parameters:
- DATA_W, 32: instruction width in bits.
- DEPTH, 32: number of words; must be ≥2 and ≤2**ADDR_W.
- ADDR_W, 5: word-index width; pc width is ADDR_W+2.
- NOP_WORD, 32'h00000000: value driven on instr when no valid instruction is present.

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous active-low reset.
- pc  in  ADDR_W+2  byte address from the PC register.
- fetch_en  in  1  1 = advance fetch; 0 = stall (hold outputs).
- flush  in  1  kill the instruction being fetched (branch/jump taken).
- instr  out  DATA_W  registered instruction.
- instr_valid  out  1  instr is a real instruction.
- addr_err  out  1  registered: last fetch was misaligned or out of range.
- load_start  in  1  pulse: begin reloading the whole memory from word 0.
- load_valid  in  1  load_data is valid.
- load_data  in  DATA_W  word to write.
- load_ready  out  1  loader accepts a word this cycle.
- load_done  out  1  one-cycle pulse after the last word is written.
- busy  out  1  high while in LOAD.

Behaviour:
- Reset (async, RST_N=0):
  - state=RUN; load counter=0.
  - instr=NOP_WORD; instr_valid=0; addr_err=0; load_ready=0; load_done=0; busy=0.
  - Memory contents are not reset.
- FSM: two states, RUN and LOAD.
  - RUN→LOAD when load_start=1. load_start has priority over fetch that cycle: the cycle fetches nothing, and next-cycle outputs are instr=NOP_WORD, instr_valid=0, addr_err=0.
  - LOAD→RUN on the cycle the handshake writes word DEPTH-1. load_done=1 for exactly the following cycle.
  - load_start while already in LOAD is ignored; the counter is not restarted.
- LOAD state:
  - load_ready=1 and busy=1.
  - Each cycle with load_valid&&load_ready: mem[cnt]<=load_data, then cnt<=cnt+1.
  - Counter resets to 0 on entry to LOAD.
  - load_valid=0 inserts wait cycles with no write.
  - Outputs held at instr=NOP_WORD, instr_valid=0, addr_err=0; fetch_en and flush are ignored.
- RUN fetch (registered, 1-cycle latency), priority highest first:
  1. flush=1 → instr<=NOP_WORD, instr_valid<=0, addr_err<=0. Flush overrides a stall.
  2. fetch_en=0 → instr, instr_valid and addr_err hold their values.
  3. fetch_en=1 with pc[1:0]!=0, or word index pc[ADDR_W+1:2]≥DEPTH → instr<=NOP_WORD, instr_valid<=0, addr_err<=1.
  4. fetch_en=1, otherwise → instr<=mem[pc[ADDR_W+1:2]], instr_valid<=1, addr_err<=0.
- Read-during-write cannot occur: fetch only happens in RUN, writes only in LOAD.
- Reset mid-LOAD returns to RUN. Words already written stay written; the remaining words keep their old contents. No load_done pulse is produced.
- Word index arithmetic is unsigned; there is no wrap. Out-of-range is an error, not an alias.

Optional Feature:
- Macro IMEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit, computed from load_data at write time.
  - New output parity_err (1 bit, registered), set together with a successful fetch when the stored parity mismatches the read data.
  - On mismatch, instr_valid still goes to 1; the core decides how to respond.
  - parity_err is cleared by reset, flush, LOAD, or the next clean fetch, and holds during a stall.
- Undefined: no parity storage, no parity_err port.

Decomposition:
- Package imem_pkg:
  - state enum {RUN, LOAD}.
  - NOP_WORD default constant.
  - parity function (reduction XOR).
  - helper computing the pc width (ADDR_W+2).
- One natural sub-module, imem_load_ctrl: FSM, load counter, load_ready, load_done and busy. The top level holds the memory array and the fetch output register.

Test Plan:
- Reset then fetch:
  - Assert RST_N=0 mid-cycle: instr=0, instr_valid=0 immediately.
  - Release, load_start, then stream words 0x24100000+i for i=0..31: load_done pulses once, the cycle after word 31.
  - Then pc=0x08 with fetch_en=1: next cycle instr=0x24100002, instr_valid=1.
- Stall and flush:
  - Fetch pc=0x04, then fetch_en=0 for 3 cycles with pc=0x10: instr stays 0x24100001.
  - flush=1 while fetch_en=0: next cycle instr=0, instr_valid=0.
- Address errors:
  - pc=0x06 (misaligned): addr_err=1, instr_valid=0.
  - Build with DEPTH=20, pc=0x50 (index 20): addr_err=1.
  - pc=0x4C (index 19): valid fetch, addr_err=0.
- Loader backpressure:
  - Toggle load_valid 1,0,1,0 across the load; load_start mid-LOAD: exactly DEPTH writes occur, busy is high throughout, and a readback of every word matches.
- Reset mid-load:
  - RST_N=0 after 10 words: state=RUN, no load_done, words 0–9 are new and word 10 is old.
- IMEM_PARITY_EN:
  - Force a flipped bit in stored word 3, then fetch pc=0x0C: parity_err=1, instr_valid=1.
  - Next fetch of pc=0x00: parity_err=0.
